// File: rtl/alu_sequencer_if.sv
// Key, ALU-result and operand/display bundle between the sequencer and its surroundings.
interface alu_sequencer_if;
    logic [3:0] KEY;
    logic [3:0] result1;
    logic [3:0] result2;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [2:0] state;
    logic [3:0] res_lo;
    logic [3:0] res_hi;
    logic       done;
    logic       busy;

    modport master (
        input  KEY, result1, result2,
        output a, b, op, state, res_lo, res_hi, done, busy
    );

    modport slave (
        output KEY, result1, result2,
        input  a, b, op, state, res_lo, res_hi, done, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Pushbutton-driven operand/op editor that runs an external ALU and captures its results.
// Optional key debouncing is enabled with macro ALU_SEQ_DEBOUNCE_EN.
module alu_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned EXEC_WAIT       = 2
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    alu_sequencer_if.master bus
);
    localparam int unsigned NKEYS    = 3;
    localparam int unsigned KEY_NEXT = 0;
    localparam int unsigned KEY_INC  = 1;
    localparam int unsigned KEY_CLR  = 2;
    localparam logic [3:0]  EXEC_LAST = 4'(EXEC_WAIT - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic               done_q, done_d;
    logic [3:0]         exec_cnt_q, exec_cnt_d;
    logic [NKEYS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NKEYS-1:0]   deb_q, deb_d, prev_q, prev_d;
    logic [NKEYS-1:0]   press_c;

    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    // KEY[3] has no function, so only the three live keys are conditioned
    always_comb begin
        sync1_d = bus.KEY[NKEYS-1:0];
        sync2_d = sync1_q;
        prev_d  = deb_q;
        press_c = prev_q & ~deb_q;
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt_q [NKEYS];
    logic [DEB_W-1:0] deb_cnt_d [NKEYS];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        for (int i = 0; i < int'(NKEYS); i++) begin
            deb_cnt_d[i] = '0;
            deb_d[i]     = deb_q[i];
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < int'(NKEYS); i++) begin
            if (reset) deb_cnt_q[i] <= '0;
            else       deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end
`else
    always_comb begin
        deb_d = sync2_q;
    end
`endif

    // Clear outranks next, next outranks increment
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        done_d     = 1'b0;
        exec_cnt_d = exec_cnt_q;

        if (press_c[KEY_CLR]) begin
            state_d    = S_A;
            a_d        = '0;
            b_d        = '0;
            op_d       = '0;
            res_lo_d   = '0;
            res_hi_d   = '0;
            exec_cnt_d = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (press_c[KEY_NEXT])     state_d = S_B;
                    else if (press_c[KEY_INC]) a_d = bcd_inc(a_q);
                end
                S_B: begin
                    if (press_c[KEY_NEXT])     state_d = S_OP;
                    else if (press_c[KEY_INC]) b_d = bcd_inc(b_q);
                end
                S_OP: begin
                    if (press_c[KEY_NEXT]) begin
                        state_d    = S_EXEC;
                        exec_cnt_d = '0;
                    end else if (press_c[KEY_INC]) begin
                        op_d = op_q + 2'd1;
                    end
                end
                S_EXEC: begin
                    if (exec_cnt_q == EXEC_LAST) begin
                        res_lo_d   = bus.result1;
                        res_hi_d   = bus.result2;
                        done_d     = 1'b1;
                        state_d    = S_SHOW;
                        exec_cnt_d = '0;
                    end else begin
                        exec_cnt_d = exec_cnt_q + 4'd1;
                    end
                end
                S_SHOW: begin
                    if (press_c[KEY_NEXT]) state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            done_q     <= 1'b0;
            exec_cnt_q <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            prev_q     <= '1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            done_q     <= done_d;
            exec_cnt_q <= exec_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            prev_q     <= prev_d;
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.op     = op_q;
    assign bus.state  = state_q;
    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == S_EXEC);
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000, which sets the number of stable CLOCK_50 cycles needed to accept a key level (10 ms at 50 MHz).
REQ-002 The module SHALL have parameter EXEC_WAIT, default 2, legal range 1..15, which sets the number of cycles the ALU operands are held before its results are captured.
REQ-003 The module SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port KEY, input, 4 bits: active-low pushbuttons. KEY[0] = next, KEY[1] = increment, KEY[2] = clear, KEY[3] unused.
REQ-006 The module SHALL have ports result1 and result2, input, 4 bits each: combinational ALU outputs.
REQ-007 The module SHALL have ports a and b, output, 4 bits each: ALU operands, BCD range 0..9.
REQ-008 The module SHALL have port op, output, 2 bits: ALU operation select.
REQ-009 The module SHALL have port state, output, 3 bits: current FSM state code, for display.
REQ-010 The module SHALL have ports res_lo and res_hi, output, 4 bits each: captured result1 and result2.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse on result capture.
REQ-012 The module SHALL have port busy, output, 1 bit: high while in S_EXEC.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer, then the debouncer (REQ-030), then a falling-edge detector that yields a one-cycle press pulse.
REQ-014 The FSM states SHALL be S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4; codes 5..7 SHALL go to S_A on the next cycle.
REQ-015 Increment in S_A SHALL set a <= a+1, with 9 wrapping to 0; in S_B it SHALL do the same for b.
REQ-016 Increment in S_OP SHALL set op <= op+1, with 3 wrapping to 0.
REQ-017 Increment in S_EXEC and S_SHOW SHALL be ignored.
REQ-018 Next SHALL cause these transitions: S_A->S_B, S_B->S_OP, S_OP->S_EXEC, S_SHOW->S_A (a, b and op retained for re-edit); next in S_EXEC SHALL be ignored.
REQ-019 S_EXEC SHALL last exactly EXEC_WAIT cycles; on its last cycle res_lo <= result1, res_hi <= result2 and done=1, and the next state SHALL be S_SHOW.
REQ-020 The a, b and op outputs SHALL be constant throughout S_EXEC and S_SHOW.
REQ-021 Clear in any state SHALL force S_A and zero a, b, op, res_lo and res_hi; clear in S_EXEC SHALL abort with no capture and no done pulse.
REQ-022 Simultaneous press pulses SHALL be resolved with priority clear > next > increment; only the highest-priority pulse acts in that cycle.
REQ-023 busy SHALL equal (state==S_EXEC); done SHALL be registered and never high for two consecutive cycles.
REQ-024 All outputs SHALL be registered, except busy, which is decoded from the state register.

Reset
REQ-025 While reset=1 at a clock edge: state=S_A; a=b=op=0; res_lo=res_hi=0; done=0; exec counter=0.
REQ-026 While reset=1 at a clock edge: synchronizer, debounced-level and edge registers SHALL be set to 1 (released), so no press pulse is produced after reset with keys idle.
REQ-027 Reset SHALL take priority over every key event.
REQ-028 Reset asserted mid-S_EXEC SHALL produce no done pulse.
REQ-029 Debounce counters SHALL be zeroed by reset.

Configuration
REQ-030 With macro ALU_SEQ_DEBOUNCE_EN defined, each key SHALL have a counter, and the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion SHALL restart the count.
REQ-031 With ALU_SEQ_DEBOUNCE_EN undefined, the debounced level SHALL equal the synchronized level and no counters SHALL be instantiated; press-to-pulse latency SHALL then be 3 cycles.

Verification (DEBOUNCE_CYCLES=4, EXEC_WAIT=2, ALU model: result1=(a+b)%10, result2=(a+b)/10)
REQ-032 Scenario: reset, then 3 clean KEY[1] presses -> a=3, state=0, b=0, op=0.
REQ-033 Scenario: a=9, then KEY[1] press -> a=0; in S_OP with op=3, KEY[1] press -> op=0.
REQ-034 Scenario: enter a=7, b=5, op=2, then next -> busy=1 for exactly 2 cycles; res_lo=2, res_hi=1; done high for exactly 1 cycle; state=4.
REQ-035 Scenario: in S_OP, KEY[0] and KEY[2] pressed in the same cycle -> state=0, a=b=op=0, no done.
REQ-036 Scenario: KEY[1] low for 2 cycles with ALU_SEQ_DEBOUNCE_EN defined -> a unchanged; same glitch without the macro -> a increments by 1.
REQ-037 Scenario: reset pulsed on the first S_EXEC cycle -> state=0, done never asserted, res_lo=res_hi=0.
